// File: rtl/tca_pkg.sv
// Shared definitions for the time-correlation analyzer counters and readout.
package tca_pkg;

  // Default widths, also used by the readout serializer.
  localparam int CNT_W = 32;
  localparam int WIN_W = 4;
  localparam int PER_W = 32;

  // Gate controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } tca_state_e;

endpackage

// File: rtl/coincidence_counter_coinc_window.sv
// Per-channel match tracking for the coincidence counter.
//
// Each channel remembers its most recent unmatched pulse with an armed flag
// and an age counter. age_x = 0 on the cycle after the pulse, so a partner
// pulse arriving in the current cycle lies age_x+1 cycles after it and may
// match only while age_x < window. Pulses must already be gated by the
// caller; clear wipes both channels at gate start.
module coinc_window #(
  parameter int WIN_W = tca_pkg::WIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             pulse_a,
  input  logic             pulse_b,
  input  logic [WIN_W-1:0] window,
  output logic             coinc
);

  logic             armed_a;
  logic             armed_b;
  logic [WIN_W:0]   age_a;
  logic [WIN_W:0]   age_b;
  logic [WIN_W:0]   win_ext;
  logic [WIN_W:0]   age_a_inc;
  logic [WIN_W:0]   age_b_inc;
  logic             live_a;
  logic             live_b;
  logic             arm_a;
  logic             arm_b;
  logic             take_a;
  logic             take_b;

  assign win_ext = {1'b0, window};

  // Match decision for the current cycle; same-cycle pairs take priority.
  always_comb begin
    coinc     = 1'b0;
    arm_a     = 1'b0;
    arm_b     = 1'b0;
    take_a    = 1'b0;
    take_b    = 1'b0;
    live_a    = armed_a && (age_a < win_ext);
    live_b    = armed_b && (age_b < win_ext);
    age_a_inc = (age_a == '1) ? age_a : age_a + {{WIN_W{1'b0}}, 1'b1};
    age_b_inc = (age_b == '1) ? age_b : age_b + {{WIN_W{1'b0}}, 1'b1};
    if (pulse_a && pulse_b) begin
      coinc = 1'b1;
    end else if (pulse_b) begin
      if (live_a) begin
        coinc  = 1'b1;
        take_a = 1'b1;
      end else begin
        arm_b = 1'b1;
      end
    end else if (pulse_a) begin
      if (live_b) begin
        coinc  = 1'b1;
        take_b = 1'b1;
      end else begin
        arm_a = 1'b1;
      end
    end
  end

  // Channel A match state: arm, consume, or age out.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      armed_a <= 1'b0;
      age_a   <= '0;
    end else if (arm_a) begin
      // With window 0 nothing can ever match a later pulse.
      armed_a <= (win_ext != '0);
      age_a   <= '0;
    end else if (take_a) begin
      armed_a <= 1'b0;
    end else if (armed_a) begin
      age_a   <= age_a_inc;
      armed_a <= (age_a_inc < win_ext);
    end
  end

  // Channel B match state: arm, consume, or age out.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      armed_b <= 1'b0;
      age_b   <= '0;
    end else if (arm_b) begin
      armed_b <= (win_ext != '0);
      age_b   <= '0;
    end else if (take_b) begin
      armed_b <= 1'b0;
    end else if (armed_b) begin
      age_b   <= age_b_inc;
      armed_b <= (age_b_inc < win_ext);
    end
  end

endmodule

// File: rtl/coincidence_counter.sv
// Gated two-channel coincidence counter.
//
// A gate of max(period,1) cycles starts the cycle after an accepted start.
// Singles and coincidences are counted into saturating working registers
// and copied to the output registers on the final counted cycle; the totals
// are then offered to the readout.
// Handshake: result_valid stays high with stable totals until a cycle in
// which result_ready is also high; that cycle completes the transfer and
// result_valid drops on the following cycle.
module coincidence_counter
  import tca_pkg::tca_state_e, tca_pkg::IDLE, tca_pkg::COUNT, tca_pkg::HOLD;
#(
  parameter int CNT_W = tca_pkg::CNT_W,
  parameter int WIN_W = tca_pkg::WIN_W,
  parameter int PER_W = tca_pkg::PER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_a,
  input  logic             pulse_b,
  input  logic [WIN_W-1:0] window,
  input  logic [PER_W-1:0] period,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic [CNT_W-1:0] count_ab,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

  tca_state_e       state;
  tca_state_e       state_nx;

  logic [PER_W-1:0] gate_cnt;
  logic [WIN_W-1:0] win_r;
  logic [CNT_W-1:0] work_a;
  logic [CNT_W-1:0] work_b;
  logic [CNT_W-1:0] work_ab;
  logic             ovf_w;

  logic             accept;
  logic             counting;
  logic             gate_last;
  logic             pa_c;
  logic             pb_c;
  logic             coinc;
  logic [CNT_W-1:0] a_nx;
  logic [CNT_W-1:0] b_nx;
  logic [CNT_W-1:0] ab_nx;
  logic             ovf_nx;

  assign accept    = (state == IDLE) && start;
  assign counting  = (state == COUNT);
  assign gate_last = (gate_cnt == PER_ONE);
  assign pa_c      = pulse_a && counting;
  assign pb_c      = pulse_b && counting;

  coinc_window #(
    .WIN_W (WIN_W)
  ) u_coinc_window (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .pulse_a (pa_c),
    .pulse_b (pb_c),
    .window  (win_r),
    .coinc   (coinc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: start only from IDLE, gate end into HOLD, handshake out.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)        state_nx = COUNT;
      COUNT:   if (gate_last)    state_nx = HOLD;
      HOLD:    if (result_ready) state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy         = (state == COUNT) || (state == HOLD);
    result_valid = (state == HOLD);
    dbg_state    = state;
  end

  // Saturating next values of the working counters and the sticky overflow.
  always_comb begin
    a_nx   = (pa_c  && work_a  != CNT_MAX) ? work_a  + CNT_ONE : work_a;
    b_nx   = (pb_c  && work_b  != CNT_MAX) ? work_b  + CNT_ONE : work_b;
    ab_nx  = (coinc && work_ab != CNT_MAX) ? work_ab + CNT_ONE : work_ab;
    ovf_nx = ovf_w
           | (pa_c  && work_a  == CNT_MAX)
           | (pb_c  && work_b  == CNT_MAX)
           | (coinc && work_ab == CNT_MAX);
  end

  // Gate counter, working counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
      win_r    <= '0;
      work_a   <= '0;
      work_b   <= '0;
      work_ab  <= '0;
      ovf_w    <= 1'b0;
      count_a  <= '0;
      count_b  <= '0;
      count_ab <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      gate_cnt <= (period == '0) ? PER_ONE : period;
      win_r    <= window;
      work_a   <= '0;
      work_b   <= '0;
      work_ab  <= '0;
      ovf_w    <= 1'b0;
    end else if (counting) begin
      work_a  <= a_nx;
      work_b  <= b_nx;
      work_ab <= ab_nx;
      ovf_w   <= ovf_nx;
      if (gate_last) begin
        // The final cycle's events are included in the published totals.
        count_a  <= a_nx;
        count_b  <= b_nx;
        count_ab <= ab_nx;
        overflow <= ovf_nx;
      end else begin
        gate_cnt <= gate_cnt - PER_ONE;
      end
    end
  end

endmodule
